// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] widths, lane typedefs and lane addressing.
// Used by the theta, rho, pi, chi and iota step blocks.
package sha3_pkg;

    localparam int LANE_W    = 64;
    localparam int ROW_LANES = 5;
    localparam int NUM_LANES = 25;
    localparam int STATE_W   = 1600;
    localparam int ROW_W     = LANE_W * ROW_LANES;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [STATE_W-1:0] state_t;

    // Bit offset of lane (x,y) inside the flat state vector (FIPS 202 order).
    function automatic int lane_base(input int x, input int y);
        return LANE_W * (ROW_LANES * y + x);
    endfunction

endpackage

// File: rtl/chi_row.sv
// Combinational chi on one row of five lanes.
// Each output lane uses only the same-z bits of its two right-hand neighbours, with wrap-around.
module chi_row
    import sha3_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [ROW_W-1:0] o_row
);

    for (genvar x = 0; x < ROW_LANES; x++) begin : g_lane
        localparam int X1 = (x + 1) % ROW_LANES;
        localparam int X2 = (x + 2) % ROW_LANES;

        lane_t w_a0;
        lane_t w_a1;
        lane_t w_a2;

        assign w_a0 = i_row[x  * LANE_W +: LANE_W];
        assign w_a1 = i_row[X1 * LANE_W +: LANE_W];
        assign w_a2 = i_row[X2 * LANE_W +: LANE_W];

        assign o_row[x * LANE_W +: LANE_W] = w_a0 ^ (~w_a1 & w_a2);
    end

endmodule

// File: rtl/chi_fun.sv
// Keccak-f[1600] chi step: five independent row transforms feeding a registered output.
// The output register only loads on a valid input, so idle-cycle input contents never reach outData.
module chi_fun
    import sha3_pkg::*;
(
    input  logic               inClk,
    input  logic               inRst,
    input  logic               inValid,
    input  logic [STATE_W-1:0] inData,
    output logic               outValid,
    output logic [STATE_W-1:0] outData
);

    state_t w_chi;
    state_t r_data;
    logic   r_valid;

    for (genvar y = 0; y < ROW_LANES; y++) begin : g_row
        chi_row u_chi_row (
            .i_row (inData[lane_base(0, y) +: ROW_W]),
            .o_row (w_chi [lane_base(0, y) +: ROW_W])
        );
    end

    // Reset wins over a same-edge valid, discarding whatever was in flight.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= inValid;
            if (inValid) begin
                r_data <= w_chi;
            end
        end
    end

    assign outData  = r_data;
    assign outValid = r_valid;

endmodule

// File: tb/tb_chi_fun.sv
// Self-checking bench for chi_fun: directed vectors from the test plan plus random traffic
// against a bit-level reference of the chi formula.
module tb_chi_fun;
    import sha3_pkg::*;

    logic   inClk = 1'b0;
    logic   inRst;
    logic   inValid;
    state_t inData;
    logic   outValid;
    state_t outData;

    int total = 0;
    int bad   = 0;

    state_t exp_data;
    logic   exp_valid;

    chi_fun dut (
        .inClk    (inClk),
        .inRst    (inRst),
        .inValid  (inValid),
        .inData   (inData),
        .outValid (outValid),
        .outData  (outData)
    );

    always #5 inClk = ~inClk;

    // Reference: applies the chi formula bit by bit using flat FIPS 202 indices.
    function automatic state_t chi_ref(input state_t s);
        state_t r;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < 64; z++) begin
                    int i0, i1, i2;
                    i0 = 64 * (5 * y + x) + z;
                    i1 = 64 * (5 * y + (x + 1) % 5) + z;
                    i2 = 64 * (5 * y + (x + 2) % 5) + z;
                    r[i0] = s[i0] ^ (~s[i1] & s[i2]);
                end
        return r;
    endfunction

    function automatic int popc(input state_t s);
        int n = 0;
        for (int i = 0; i < STATE_W; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic int first_diff(input state_t a, input state_t b);
        for (int i = 0; i < STATE_W; i++)
            if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int w = 0; w < STATE_W / 32; w++) s[w * 32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic check_data(input string tag, input state_t got, input state_t want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got_popcount=%0d want_popcount=%0d first_diff_bit=%0d",
                   tag, popc(got), popc(want), first_diff(got, want));
        end
    endtask

    task automatic check_valid(input string tag, input logic got, input logic want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    // Drive on the falling edge, clock once, update the model, then sample 1 time unit later.
    task automatic step(input logic rst, input logic vld, input state_t d, input string tag);
        @(negedge inClk);
        inRst   = rst;
        inValid = vld;
        inData  = d;
        @(posedge inClk);
        if (rst) begin
            exp_data  = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = vld;
            if (vld) exp_data = chi_ref(d);
        end
        #1;
        check_valid({tag, "_valid"}, outValid, exp_valid);
        check_data ({tag, "_data"},  outData,  exp_data);
    endtask

    function automatic state_t two_bits(input int a, input int b);
        state_t s;
        s = '0;
        s[a] = 1'b1;
        s[b] = 1'b1;
        return s;
    endfunction

    function automatic state_t one_bit(input int a);
        state_t s;
        s = '0;
        s[a] = 1'b1;
        return s;
    endfunction

    initial begin
        state_t held;
        inRst     = 1'b1;
        inValid   = 1'b0;
        inData    = '0;
        exp_data  = '0;
        exp_valid = 1'b0;

        step(1'b1, 1'b0, '0, "reset");
        step(1'b1, 1'b0, '0, "reset2");
        step(1'b0, 1'b0, rand_state(), "idle_after_reset");

        step(1'b0, 1'b1, '0, "all_zero");
        check_data("all_zero_abs", outData, '0);

        step(1'b0, 1'b1, '1, "all_ones");
        check_data("all_ones_abs", outData, '1);

        step(1'b0, 1'b1, one_bit(64), "bit64");
        check_data("bit64_abs", outData, two_bits(64, 256));

        step(1'b0, 1'b1, one_bit(133), "bit133");
        check_data("bit133_abs", outData, two_bits(5, 133));

        step(1'b0, 1'b1, one_bit(1343), "bit1343");
        check_data("bit1343_abs", outData, two_bits(1343, 1535));

        // Reset pulse with valid nonzero data, then the next valid input.
        step(1'b0, 1'b1, rand_state(), "pre_rst");
        step(1'b1, 1'b1, rand_state(), "rst_with_valid");
        check_data("rst_with_valid_abs", outData, '0);
        step(1'b0, 1'b1, rand_state(), "post_rst");

        // Valid dropped for three cycles with junk on inData: output held.
        held = outData;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 'x, "hold");
            check_data("hold_abs", outData, held);
        end
        step(1'b0, 1'b0, rand_state(), "hold_random");

        for (int k = 0; k < 40; k++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), rand_state(), "random");
        end

        step(1'b1, 1'b0, '0, "final_reset");
        step(1'b0, 1'b0, '1, "final_idle");
        check_data("final_idle_abs", outData, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
